// File: rtl/range_count_sequencer_if.sv
// Command channel of the range count sequencer: {lo, hi, reps} offered on a
// valid/ready handshake from a control master.
interface range_count_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_lo;
  logic [WIDTH-1:0] cmd_hi;
  logic [RPT_W-1:0] cmd_reps;

  modport master (
    output cmd_valid,
    output cmd_lo,
    output cmd_hi,
    output cmd_reps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_lo,
    input  cmd_hi,
    input  cmd_reps,
    output cmd_ready
  );
endinterface

// File: rtl/range_count_sequencer.sv
// Steps a counter from lo to hi inclusive for reps passes (0 = free-run),
// with pause, abort, wrap/done/err strobes and out-of-window self-correction.
module range_count_sequencer #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  range_count_sequencer_if.slave cmd,
  input  logic                   pause_i,
  input  logic                   abort_i,
  output logic [WIDTH-1:0]       count_o,
  output logic                   count_valid_o,
  output logic                   wrap_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] count_q;
  logic [RPT_W-1:0] reps_q;
  logic             err_q;

  logic in_run;
  logic in_window;
  logic at_hi;
  logic last_pass;
  logic cmd_bad;

  assign in_run    = (state_q == S_RUN);
  assign in_window = (count_q >= lo_q) && (count_q <= hi_q);
  assign at_hi     = (count_q == hi_q);
  assign last_pass = (reps_q == RPT_W'(1));
  assign cmd_bad   = (cmd.cmd_lo > cmd.cmd_hi);

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign count_o       = count_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;

  // An out-of-window count is never presented as a sequence value.
  assign count_valid_o = in_run && !pause_i && in_window;
  assign wrap_o        = in_run && !pause_i && !abort_i && in_window && at_hi && !last_pass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      count_q <= '0;
      reps_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              lo_q    <= cmd.cmd_lo;
              hi_q    <= cmd.cmd_hi;
              reps_q  <= cmd.cmd_reps;
              count_q <= cmd.cmd_lo;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Abort outranks pause, self-correction and end-of-pass detection.
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (!in_window) begin
            count_q <= lo_q;
          end else if (!pause_i) begin
            if (!at_hi) begin
              count_q <= count_q + 1'b1;
            end else if (last_pass) begin
              state_q <= S_DONE;
            end else begin
              count_q <= lo_q;
              if (reps_q != '0) begin
                reps_q <= reps_q - 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_count_sequencer.sv
// Self-checking bench: sequence-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_range_count_sequencer;
  localparam int WIDTH = 8;
  localparam int RPT_W = 4;

  logic             clk_i;
  logic             rst_ni;
  logic             pause_i;
  logic             abort_i;
  logic [WIDTH-1:0] count_o;
  logic             count_valid_o;
  logic             wrap_o;
  logic             done_o;
  logic             err_o;
  logic             busy_o;

  range_count_sequencer_if #(.WIDTH(WIDTH), .RPT_W(RPT_W)) rif ();

  range_count_sequencer #(.WIDTH(WIDTH), .RPT_W(RPT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmd           (rif),
    .pause_i       (pause_i),
    .abort_i       (abort_i),
    .count_o       (count_o),
    .count_valid_o (count_valid_o),
    .wrap_o        (wrap_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the run is a flat sequence of len*reps values indexed by m_idx.
  int m_lo, m_hi, m_reps, m_idx, m_len, m_count;
  bit m_run, m_done, m_err;

  always @(negedge clk_i) begin
    bit e_valid, e_wrap, e_busy, was_done;
    if (!rst_ni) begin
      m_run = 0; m_done = 0; m_err = 0; m_count = 0;
      chk("rst_count", int'(count_o), 0);
      chk("rst_valid", int'(count_valid_o), 0);
      chk("rst_wrap", int'(wrap_o), 0);
      chk("rst_done", int'(done_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_ready", int'(rif.cmd_ready), 1);
    end else begin
      e_valid = m_run && !pause_i;
      e_wrap  = m_run && !pause_i && !abort_i && (m_idx % m_len == m_len - 1)
                && (m_reps == 0 || m_idx / m_len < m_reps - 1);
      e_busy  = m_run || m_done;
      chk("count", int'(count_o), m_count);
      chk("count_valid", int'(count_valid_o), int'(e_valid));
      chk("wrap", int'(wrap_o), int'(e_wrap));
      chk("done", int'(done_o), int'(m_done));
      chk("err", int'(err_o), int'(m_err));
      chk("busy", int'(busy_o), int'(e_busy));
      chk("cmd_ready", int'(rif.cmd_ready), int'(!e_busy));
      was_done = m_done;
      m_err = 0;
      m_done = 0;
      if (m_run) begin
        if (abort_i) begin
          m_run = 0;
        end else if (!pause_i) begin
          if (m_reps != 0 && m_idx + 1 == m_len * m_reps) begin
            m_run = 0;
            m_done = 1;
          end else begin
            m_idx++;
            m_count = m_lo + m_idx % m_len;
          end
        end
      end else if (!was_done && rif.cmd_valid) begin
        if (int'(rif.cmd_lo) > int'(rif.cmd_hi)) begin
          m_err = 1;
        end else begin
          m_lo = int'(rif.cmd_lo); m_hi = int'(rif.cmd_hi); m_reps = int'(rif.cmd_reps);
          m_len = m_hi - m_lo + 1; m_idx = 0; m_count = m_lo; m_run = 1;
        end
      end
    end
  end

  // Observation log for the directed scenarios.
  int seen[$];
  int wrap_cnt, done_cnt, busy_cyc;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (count_valid_o) seen.push_back(int'(count_o));
      if (wrap_o) wrap_cnt++;
      if (done_o) done_cnt++;
      if (busy_o) busy_cyc++;
    end
  end

  task automatic clear_log();
    seen.delete();
    wrap_cnt = 0; done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic chk_seq(input string name, input int exp[$]);
    chk({name, "_len"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++)
      chk($sformatf("%s[%0d]", name, i), seen[i], exp[i]);
  endtask

  task automatic chk_range(input string name, input int lo, input int hi);
    int exp[$];
    for (int v = lo; v <= hi; v++) exp.push_back(v);
    chk_seq(name, exp);
  endtask

  task automatic send_cmd(input int lo, input int hi, input int reps);
    int w = 0;
    rif.cmd_lo = WIDTH'(lo); rif.cmd_hi = WIDTH'(hi); rif.cmd_reps = RPT_W'(reps);
    rif.cmd_valid = 1'b1;
    while (!rif.cmd_ready && w < 500) begin
      @(posedge clk_i); #1; w++;
    end
    if (w >= 500) chk("accept_timeout", 0, 1);
    @(posedge clk_i); #1;
    rif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!rif.cmd_ready && w < 2000) begin
      @(posedge clk_i); #1; w++;
    end
    if (w >= 2000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int prev, w, lo, hi, reps, lim, cyc;
    rst_ni = 1'b0; pause_i = 1'b0; abort_i = 1'b0;
    rif.cmd_valid = 1'b0; rif.cmd_lo = '0; rif.cmd_hi = '0; rif.cmd_reps = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk("init_count", int'(count_o), 0);
    chk("init_ready", int'(rif.cmd_ready), 1);

    // Single pass 10..40.
    clear_log();
    send_cmd(10, 40, 1);
    wait_idle();
    chk_range("pass10_40", 10, 40);
    chk("pass10_40_done", done_cnt, 1);
    chk("pass10_40_busy", busy_cyc, 32);
    chk("pass10_40_wrap", wrap_cnt, 0);

    // Three passes 3..5.
    clear_log();
    send_cmd(3, 5, 3);
    wait_idle();
    chk_seq("rep3", '{3, 4, 5, 3, 4, 5, 3, 4, 5});
    chk("rep3_wrap", wrap_cnt, 2);
    chk("rep3_done", done_cnt, 1);

    // Pause for 4 cycles while count is 20.
    clear_log();
    send_cmd(10, 40, 1);
    w = 0;
    while (count_o != 8'd20 && w < 100) begin
      @(posedge clk_i); #1; w++;
    end
    pause_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1 pause_i = 1'b0;
    wait_idle();
    chk_range("pause", 10, 40);
    chk("pause_busy", busy_cyc, 36);

    // Free-run single value, aborted during the fifth valid cycle.
    clear_log();
    send_cmd(7, 7, 0);
    repeat (4) begin @(posedge clk_i); #1; end
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    chk_seq("abort", '{7, 7, 7, 7, 7});
    chk("abort_done", done_cnt, 0);
    chk("abort_ready", int'(rif.cmd_ready), 1);
    chk("abort_wrap", wrap_cnt, 4);

    // Rejected command, then a command held off while running.
    prev = int'(count_o);
    send_cmd(50, 20, 1);
    chk("reject_err", int'(err_o), 1);
    chk("reject_busy", int'(busy_o), 0);
    chk("reject_count", int'(count_o), prev);
    clear_log();
    send_cmd(1, 4, 2);
    chk("held_ready", int'(rif.cmd_ready), 0);
    send_cmd(100, 101, 1);
    wait_idle();
    chk_seq("held", '{1, 2, 3, 4, 1, 2, 3, 4, 100, 101});
    chk("held_done", done_cnt, 2);

    // Asynchronous reset mid-run.
    send_cmd(20, 30, 1);
    w = 0;
    while (count_o != 8'd25 && w < 100) begin
      @(posedge clk_i); #1; w++;
    end
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_count", int'(count_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_valid", int'(count_valid_o), 0);
    chk("arst_ready", int'(rif.cmd_ready), 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    clear_log();
    send_cmd(5, 6, 1);
    wait_idle();
    chk_seq("post_rst", '{5, 6});
    chk("post_rst_done", done_cnt, 1);

    // Randomized commands with pause and abort.
    for (int i = 0; i < 40; i++) begin
      lo = int'($urandom_range(0, 60));
      hi = lo + int'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) begin
        w = lo; lo = hi + 1; hi = w;
      end
      reps = int'($urandom_range(0, 3));
      lim = int'($urandom_range(3, 40));
      send_cmd(lo, hi, reps);
      cyc = 0;
      while (busy_o && cyc < 400) begin
        pause_i = ($urandom_range(0, 4) == 0);
        abort_i = (cyc > lim && reps == 0) || ($urandom_range(0, 49) == 0);
        @(posedge clk_i); #1;
        cyc++;
      end
      pause_i = 1'b0; abort_i = 1'b0;
      if (cyc >= 400) chk("rand_timeout", 0, 1);
      @(posedge clk_i); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/range_count_sequencer.md
# range_count_sequencer

Command-driven sequencer for the team's bounded up-counter datapath. It accepts a `{lo, hi, reps}` command over a valid/ready handshake and then steps a counter from `lo` to `hi` inclusive, repeating the pass `reps` times. It supports pause and abort and emits wrap and done strobes. It sits between a control master (CPU register block or test FSM) and consumers that need a programmable count window, such as the 10-to-40 style range counters.

## Interface
Parameters:
- `WIDTH`, default 8: counter and bound width.
- `RPT_W`, default 4: repeat-count width.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_lo` in WIDTH: first count value.
- `cmd_hi` in WIDTH: last count value.
- `cmd_reps` in RPT_W: number of passes; 0 means free-run until abort.
- `pause` in 1: hold the counter while high.
- `abort` in 1: terminate the sequence.
- `count` out WIDTH: current count.
- `count_valid` out 1: `count` is a new sequence value this cycle.
- `wrap` out 1: one-cycle strobe on the last value of a non-final pass.
- `done` out 1: one-cycle strobe after the final pass completes.
- `err` out 1: one-cycle strobe when a command is rejected.
- `busy` out 1: state is not IDLE.

## Operation
- States are IDLE, RUN, DONE. Reset forces IDLE with all registers cleared.
- **IDLE**
  - `cmd_ready` is 1.
  - On `cmd_valid && cmd_ready`:
    - If `cmd_lo > cmd_hi` (unsigned): `err` = 1 on the next cycle and the block stays in IDLE.
    - Otherwise: latch `lo`, `hi`, `reps_left = cmd_reps`; set `count <= cmd_lo`; go to RUN.
  - `count` holds its last value in IDLE.
- **RUN**
  - `count_valid = !pause` (combinational).
  - If `pause` is high, nothing advances.
  - Otherwise, at the edge:
    - If `count != hi`: `count <= count + 1`.
    - If `count == hi` and (`reps_left == 0` (free-run) or `reps_left > 1`): `count <= lo`, decrement `reps_left` unless free-run, and `wrap` = 1 combinationally in that same cycle.
    - If `count == hi` and `reps_left == 1`: go to DONE, `count` holds `hi`.
- **Self-correction:** in RUN, if `count < lo` or `count > hi`, `count <= lo` at the next edge and `count_valid` = 0 that cycle.
- **DONE**
  - `done` = 1 and `count_valid` = 0.
  - Unconditional return to IDLE next cycle.
- **Abort**
  - `abort` high in RUN: next state is IDLE, `count` holds, and `done`/`wrap` are not asserted.
  - `abort` has priority over `pause` and over `hi` detection.
  - `abort` is ignored in IDLE and DONE.
- `cmd_ready = (state == IDLE)`. Commands presented in RUN or DONE are not accepted and must be held by the master.
- Arithmetic:
  - The `count + 1` increment never overflows, because `count < hi <= 2^WIDTH - 1`.
  - `lo == hi` is legal: a single value per pass.
- `busy = (state != IDLE)`.

## Timing
- Reset values: `count` = 0, `count_valid` = 0, `wrap` = 0, `done` = 0, `err` = 0, `busy` = 0, `cmd_ready` = 1.
  - While `rst` is low, commands are ignored.
- Latency:
  - Command accepted at edge N: the first `count_valid` with `count == lo` occurs in cycle N+1.
  - The last valid value is `hi` of the final pass.
  - `done` occurs one cycle after that value.
- Unpaused run of R passes: exactly (hi − lo + 1)·R cycles with `count_valid` = 1, then 1 `done` cycle.
- Each pause cycle adds one cycle; no value is duplicated or skipped.
- `err` occurs one cycle after the rejected handshake.
- Earliest next command accept: the cycle after DONE (IDLE).
- Reset asserted mid-RUN: immediate (asynchronous) return to reset values; no `done`.

## Test plan
- Reset then command `lo=10`, `hi=40`, `reps=1` -> `count_valid` for 31 cycles, values 10..40 in order, `done` one cycle later, `busy` low after.
- `lo=3`, `hi=5`, `reps=3` -> sequence 3,4,5,3,4,5,3,4,5; `wrap` high on the first two 5s only; single `done`.
- `lo=10`, `hi=40`, `reps=1`, `pause` high for 4 cycles while `count=20` -> 20 held with `count_valid`=0, resumes at 21, total run length 31+4 cycles, no gaps or repeats.
- `lo=7`, `hi=7`, `reps=0`, abort after 5 valid cycles -> five 7s, IDLE next cycle, `done`=0, `cmd_ready`=1.
- Command `lo=50`, `hi=20` -> `err` one cycle, stays IDLE, `count` unchanged; second command issued during RUN is not accepted (`cmd_ready`=0) until after `done`.
- `rst` low while RUN at `count=25` -> all outputs return to reset values asynchronously; a new command after release starts cleanly from its `lo`.
